// File: rtl/alu_pkg.sv
//--------------------------------------------------------------------
// alu_pkg : shared encodings for the bit-serial 4-bit ALU
// Rev 1.0 : initial release
//--------------------------------------------------------------------
`default_nettype none

package alu_pkg;

  localparam int DEFAULT_W = 4;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/serial_bit_cell.sv
//--------------------------------------------------------------------
// serial_bit_cell : one-bit combinational AND/OR/add/subtract slice
// Rev 1.0 : initial release
//--------------------------------------------------------------------
`default_nettype none

module serial_bit_cell
  import alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [1:0] op,
  output logic       s,
  output logic       cout
);

  logic w_b;

  always_comb begin
    w_b  = (op == OP_SUB) ? ~b : b;
    s    = 1'b0;
    cout = 1'b0;
    case (op)
      OP_AND: s = a & b;
      OP_OR:  s = a | b;
      default: begin
        s    = a ^ w_b ^ cin;
        cout = (a & w_b) | (a & cin) | (w_b & cin);
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/serial_alu4.sv
//--------------------------------------------------------------------
// serial_alu4 : bit-serial ALU, one result bit per clock, LSB first
// Rev 1.0 : initial release
//--------------------------------------------------------------------
`default_nettype none

module serial_alu4
  import alu_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] S,
  output logic         Co
);

  localparam int          CW   = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_carry;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [1:0]    r_op;
  logic [W-1:0]  r_sh;

  logic          w_s;
  logic          w_cout;
  logic [W-1:0]  w_sh_next;

  serial_bit_cell u_cell (
    .a    (r_a[r_cnt]),
    .b    (r_b[r_cnt]),
    .cin  (r_carry),
    .op   (r_op),
    .s    (w_s),
    .cout (w_cout)
  );

  // New bits enter at the MSB so bit 0 lands at the LSB after W shifts.
  assign w_sh_next = {w_s, r_sh[W-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      S       <= '0;
      Co      <= 1'b0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= OP_AND;
      r_sh    <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= ST_IDLE;
          if (start) begin
            r_a     <= A;
            r_b     <= B;
            r_op    <= op;
            r_cnt   <= '0;
            r_carry <= (op == OP_SUB);
            r_state <= ST_RUN;
            busy    <= 1'b1;
          end
        end
        ST_RUN: begin
          r_sh    <= w_sh_next;
          r_carry <= w_cout;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            S       <= w_sh_next;
            Co      <= ((r_op == OP_ADD) || (r_op == OP_SUB)) ? w_cout : 1'b0;
            r_state <= ST_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_alu4.sv
//--------------------------------------------------------------------
// tb_serial_alu4 : directed and random checks of serial_alu4
// Rev 1.0 : initial release
//--------------------------------------------------------------------
`default_nettype none

module tb_serial_alu4;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] S;
  logic         Co;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_s  = '0;
  logic         exp_co = 1'b0;

  serial_alu4 #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .S     (S),
    .Co    (Co)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference result straight from the arithmetic definition of each op.
  task automatic model(input int a, input int b, input int o,
                       output logic [W-1:0] s, output logic c);
    int r;
    r = 0;
    c = 1'b0;
    case (o)
      0: r = a & b;
      1: r = a | b;
      2: begin r = a + b; c = r[W]; end
      default: begin r = a + ((~b) & ((1 << W) - 1)) + 1; c = r[W]; end
    endcase
    s = r[W-1:0];
  endtask

  // Caller has already driven start=1 and operands before the sampling edge.
  task automatic run_op(input int a, input int b, input int o, input bit noisy);
    logic [W-1:0] ns;
    logic         nc;
    model(a, b, o, ns, nc);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      check($sformatf("busy_run%0d", i), {31'd0, busy}, 32'd1);
      check($sformatf("done_run%0d", i), {31'd0, done}, 32'd0);
      check($sformatf("hold_s%0d", i), {28'd0, S}, {28'd0, exp_s});
      if (noisy) begin
        start = 1'($urandom);
        A     = W'($urandom);
        B     = W'($urandom);
        op    = 2'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    exp_s  = ns;
    exp_co = nc;
    check("done_pulse", {31'd0, done}, 32'd1);
    check("busy_done", {31'd0, busy}, 32'd0);
    check($sformatf("S_op%0d_%0h_%0h", o, a, b), {28'd0, S}, {28'd0, exp_s});
    check($sformatf("Co_op%0d_%0h_%0h", o, a, b), {31'd0, Co}, {31'd0, exp_co});
    start = 1'b0;
  endtask

  task automatic issue(input int a, input int b, input int o);
    start = 1'b1;
    A     = W'(a);
    B     = W'(b);
    op    = 2'(o);
  endtask

  initial begin
    int a, b, o;
    #1 rst_n = 1'b0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_S", {28'd0, S}, 32'd0);
    check("rst_Co", {31'd0, Co}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // AND directed
    issue('b1100, 'b1010, 0);
    run_op('b1100, 'b1010, 0, 1'b0);
    @(negedge clk);
    check("idle_after_done", {31'd0, done | busy}, 32'd0);

    // ADD overflow and SUB with borrow
    issue('b1111, 'b0001, 2);
    run_op('b1111, 'b0001, 2, 1'b0);
    @(negedge clk);
    issue('b0011, 'b0101, 3);
    run_op('b0011, 'b0101, 3, 1'b0);
    @(negedge clk);

    // start held and operands scrambled during RUN
    issue('b0110, 'b0011, 2);
    run_op('b0110, 'b0011, 2, 1'b1);
    @(negedge clk);
    check("no_extra_done", {31'd0, done}, 32'd0);

    // reset in the 2nd RUN cycle
    issue('b1010, 'b0101, 1);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_s  = '0;
    exp_co = 1'b0;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_S", {28'd0, S}, 32'd0);
    check("midrst_Co", {31'd0, Co}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      check("post_rst_quiet", {31'd0, done | busy}, 32'd0);
    end

    // back-to-back: start held through DONE
    issue('b0101, 'b0110, 0);
    run_op('b0101, 'b0110, 0, 1'b0);
    issue('b0111, 'b0001, 2);
    run_op('b0111, 'b0001, 2, 1'b0);
    @(negedge clk);

    // random operations, mixed spacing and noise
    for (int n = 0; n < 40; n++) begin
      a = int'($urandom_range(0, (1 << W) - 1));
      b = int'($urandom_range(0, (1 << W) - 1));
      o = int'($urandom_range(0, 3));
      issue(a, b, o);
      run_op(a, b, o, 1'($urandom));
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
